// File: rtl/logicnets_enc_pkg.sv
// Shared types and helpers for the LogicNets input encoder:
// the FSM state enum, the quantizer result type, clog2 and the
// shift/saturate/offset quantizer.
package logicnets_enc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUT
    } enc_state_t;

    typedef struct packed {
        logic [15:0] code;
        logic        clip;
    } sat_res_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Arithmetic floor shift, clamp to the signed QBITS range, then offset
    // to an unsigned code. The clip flag marks a clamped value.
    function automatic sat_res_t sat_code(input logic signed [63:0] sum,
                                          input int unsigned       shift,
                                          input int unsigned       qbits);
        sat_res_t          r;
        logic signed [63:0] q;
        logic signed [63:0] half;
        half   = 64'sd1 <<< (qbits - 1);
        q      = sum >>> shift;
        r.clip = 1'b0;
        if (q > half - 64'sd1) begin
            q      = half - 64'sd1;
            r.clip = 1'b1;
        end else if (q < -half) begin
            q      = -half;
            r.clip = 1'b1;
        end
        q      = q + half;
        r.code = q[15:0];
        return r;
    endfunction

endpackage

// File: rtl/enc_bin_accum.sv
// One bin accumulator (I or Q) with load/add/close control and the
// quantizer applied to the sum that includes the closing sample.
module enc_bin_accum
    import logicnets_enc_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 12,
    parameter int unsigned BIN_LEN  = 16,
    parameter int unsigned QBITS    = 2,
    parameter int unsigned SHIFT    = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic                       add,
    input  logic                       close,
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic [QBITS-1:0]           code,
    output logic                       clip
);

    localparam int unsigned ACC_W = SAMPLE_W + clog2(BIN_LEN);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] sum;
    sat_res_t                res;
    logic                    unused_code_hi;

    // Next accumulator value and quantized code of the running sum
    always_comb begin
        sum   = acc_q + ACC_W'(sample);
        acc_d = acc_q;
        if (load) begin
            acc_d = ACC_W'(sample);
        end else if (close) begin
            acc_d = '0;
        end else if (add) begin
            acc_d = sum;
        end
        res  = sat_code(64'(sum), SHIFT, QBITS);
        code = res.code[QBITS-1:0];
        clip = res.clip;
    end

    assign unused_code_hi = ^res.code[15:QBITS];

    // Accumulator register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/logicnets_input_encoder.sv
// Streaming I/Q bin integrator and quantizer feeding the first LUT layer.
// Build option: LOGICNETS_ENC_SAT_CNT_EN enables the saturation counter;
// otherwise sat_cnt is tied to zero.
module logicnets_input_encoder
    import logicnets_enc_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 12,
    parameter int unsigned BIN_LEN  = 16,
    parameter int unsigned NUM_BINS = 4,
    parameter int unsigned QBITS    = 2,
    parameter int unsigned SHIFT    = 12
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic                           s_start,
    input  logic signed [SAMPLE_W-1:0]     s_i,
    input  logic signed [SAMPLE_W-1:0]     s_q,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [2*QBITS*NUM_BINS-1:0]    m_data,
    output logic [15:0]                    sat_cnt
);

    localparam int unsigned DATA_W = 2 * QBITS * NUM_BINS;
    localparam int unsigned CNT_W  = clog2(BIN_LEN) + 1;
    localparam int unsigned BIN_W  = (NUM_BINS > 1) ? clog2(NUM_BINS) : 1;

    enc_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic [DATA_W-1:0] feat_q, feat_d;

    logic             accept;
    logic             load;
    logic             add;
    logic             close;
    logic             last;
    logic [QBITS-1:0] code_i;
    logic [QBITS-1:0] code_q;
    logic             clip_i;
    logic             clip_q;

    // Handshake and accumulator control decode
    always_comb begin
        s_ready = (state_q != OUT);
        m_valid = (state_q == OUT);
        accept  = s_valid && s_ready;
        load    = accept && s_start;
        add     = accept && !s_start && (state_q == ACCUM);
        close   = add && (cnt_q == CNT_W'(BIN_LEN - 1));
        last    = close && (bin_q == BIN_W'(NUM_BINS - 1));
    end

    enc_bin_accum #(
        .SAMPLE_W (SAMPLE_W),
        .BIN_LEN  (BIN_LEN),
        .QBITS    (QBITS),
        .SHIFT    (SHIFT)
    ) u_acc_i (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .add    (add),
        .close  (close),
        .sample (s_i),
        .code   (code_i),
        .clip   (clip_i)
    );

    enc_bin_accum #(
        .SAMPLE_W (SAMPLE_W),
        .BIN_LEN  (BIN_LEN),
        .QBITS    (QBITS),
        .SHIFT    (SHIFT)
    ) u_acc_q (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .add    (add),
        .close  (close),
        .sample (s_q),
        .code   (code_q),
        .clip   (clip_q)
    );

    // Next state, sample/bin counters and feature register update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        feat_d  = feat_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    cnt_d   = CNT_W'(1);
                    bin_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (load) begin
                    // resync: partial bins are simply overwritten by the new shot
                    cnt_d = CNT_W'(1);
                    bin_d = '0;
                end else if (close) begin
                    cnt_d = '0;
                    bin_d = bin_q + BIN_W'(1);
                    feat_d[2*QBITS*bin_q +: QBITS]         = code_i;
                    feat_d[2*QBITS*bin_q + QBITS +: QBITS] = code_q;
                    if (last) begin
                        bin_d   = '0;
                        state_d = OUT;
                    end
                end else if (add) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            OUT: begin
                if (m_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and feature registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            feat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            feat_q  <= feat_d;
        end
    end

    assign m_data = feat_q;

`ifdef LOGICNETS_ENC_SAT_CNT_EN
    logic [15:0] sat_q, sat_d;
    logic [16:0] sat_sum;

    // Saturating count of clipped I and Q codes at each bin close
    always_comb begin
        sat_sum = {1'b0, sat_q} + 17'(clip_i & close) + 17'(clip_q & close);
        sat_d   = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end

    // Saturation counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= '0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_cnt = sat_q;
`else
    logic unused_clip;
    assign unused_clip = clip_i ^ clip_q;
    assign sat_cnt     = '0;
`endif

endmodule

// File: tb/tb_logicnets_input_encoder.sv
// Scoreboard bench for logicnets_input_encoder: the driver pushes the
// expected vector per shot, a monitor pops and compares on each accepted
// output vector. Expected sat_cnt follows LOGICNETS_ENC_SAT_CNT_EN.
module tb_logicnets_input_encoder;

    typedef struct {
        logic [15:0] data;
        logic [15:0] sat;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               s_valid;
    logic               s_ready;
    logic               s_start;
    logic signed [11:0] s_i;
    logic signed [11:0] s_q;
    logic               m_valid;
    logic               m_ready;
    logic [15:0]        m_data;
    logic [15:0]        sat_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_sat  = '0;
    exp_t        sb[$];

    logicnets_input_encoder #(
        .SAMPLE_W (12),
        .BIN_LEN  (16),
        .NUM_BINS (4),
        .QBITS    (2),
        .SHIFT    (12)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_start (s_start),
        .s_i     (s_i),
        .s_q     (s_q),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .sat_cnt (sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every accepted vector must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_vector: got %h expected none", m_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("m_data", 32'(m_data), 32'(e.data));
                chk("sat_cnt", 32'(sat_cnt), 32'(e.sat));
            end
        end
    end

    task automatic put(input logic st, input logic [11:0] i, input logic [11:0] q);
        s_valid = 1'b1;
        s_start = st;
        s_i     = i;
        s_q     = q;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_start = 1'b0;
    endtask

    // iv/qv hold per-bin sample values, bin 0 in the low 12 bits.
    // hold < 0 leaves the vector pending in OUT.
    task automatic shot(input logic [47:0] iv, input logic [47:0] qv,
                        input logic [15:0] exp_d, input int clips,
                        input int hold, input int stall_at);
        exp_t e;
`ifdef LOGICNETS_ENC_SAT_CNT_EN
        exp_sat = exp_sat + 16'(clips);
`else
        if (clips < 0) exp_sat = '0;
`endif
        e.data = exp_d;
        e.sat  = exp_sat;
        sb.push_back(e);
        for (int k = 0; k < 64; k++) begin
            if (k == stall_at) begin
                // idle cycles with a stray s_start must not count or resync
                repeat (3) begin
                    s_valid = 1'b0;
                    s_start = 1'b1;
                    @(posedge clk);
                    #1;
                end
                s_start = 1'b0;
            end
            if (k == 63) chk("m_valid_before_last", 32'(m_valid), 32'd0);
            put(k == 0, iv[12*(k/16) +: 12], qv[12*(k/16) +: 12]);
        end
        chk("latency_m_valid", 32'(m_valid), 32'd1);
        chk("out_s_ready", 32'(s_ready), 32'd0);
        if (hold < 0) return;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("bp_m_data", 32'(m_data), 32'(exp_d));
            chk("bp_s_ready", 32'(s_ready), 32'd0);
            chk("bp_m_valid", 32'(m_valid), 32'd1);
        end
        if (hold > 0) begin
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        chk("post_accept_m_valid", 32'(m_valid), 32'd0);
        chk("post_accept_s_ready", 32'(s_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_start = 1'b0;
        s_i     = '0;
        s_q     = '0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // full saturation: I codes 3, Q codes 0 -> 4'h3 per bin, 8 clips
        shot({4{12'sd1024}}, {4{-12'sd1024}}, 16'h3333, 8, 0, -1);

        // zero input with 10 cycles of backpressure: code 2 everywhere
        shot('0, '0, 16'hAAAA, 0, 10, -1);

        // unclipped: bin0 I=256 (code 3), bin1 I=-1 (code 1), rest 0;
        // Q code 2 -> nibbles B, 9, A, A
        shot({12'd0, 12'd0, 12'hFFF, 12'd256}, '0, 16'hAA9B, 0, 0, 20);

        // samples without s_start in IDLE are discarded
        for (int k = 0; k < 5; k++) put(1'b0, 12'd1024, 12'd1024);
        chk("idle_discard_m_valid", 32'(m_valid), 32'd0);

        // resync: 29 samples of an aborted shot, restart on sample 30
        for (int k = 0; k < 29; k++) put(k == 0, 12'd256, 12'd0);
        shot('0, '0, 16'hAAAA, 0, 0, -1);

        // async reset while a vector is pending in OUT
        shot({4{12'sd1024}}, {4{-12'sd1024}}, 16'h3333, 8, -1, -1);
        chk("pre_reset_m_data", 32'(m_data), 32'h3333);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_m_valid", 32'(m_valid), 32'd0);
        chk("async_rst_m_data", 32'(m_data), 32'd0);
        chk("async_rst_sat_cnt", 32'(sat_cnt), 32'd0);
        void'(sb.pop_back());
        exp_sat = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // recovery after reset
        shot({4{12'sd1024}}, {4{-12'sd1024}}, 16'h3333, 8, 2, -1);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
